tsn_dgcl_resp: RTL and testbench
================================

TSN_DGCL_RESP -- requirements
Module: tsn_dgcl_resp

Interface
REQ-001 SHALL have parameter MEM_AW, default 16, local memory word-address width (one word = 128 bits).
REQ-002 SHALL have one clock and an asynchronous, active-high reset: gemmini_clk in 1 (only clock); reset in 1 (async, active-high).
REQ-003 SHALL have port rcc_valid in 1: read command offered.
REQ-004 SHALL have port rcc_ready out 1: read command accepted when high together with rcc_valid.
REQ-005 SHALL have port rcc_dram_addr in 40: byte address; word address = bits [MEM_AW+3:4].
REQ-006 SHALL have port rcc_dpram_addr in 16: tag echoed on rcd.
REQ-007 SHALL have port rcc_length in 16: burst length in 128-bit beats.
REQ-008 SHALL have ports rcd_valid out 1 and rcd_ready in 1: read-data handshake.
REQ-009 SHALL have ports rcd_read_data out 128, rcd_dpram_addr out 16 and rcd_length out 16: beat data plus the command tag and length.
REQ-010 SHALL have ports wcc_valid in 1 and wcc_ready out 1: write-beat handshake.
REQ-011 SHALL have ports wcc_dram_addr in 40, wcc_write_data in 128, wcc_dpram_addr in 16 and wcc_length in 16: single-beat write; wcc_dpram_addr and wcc_length are reserved and ignored.
REQ-012 SHALL have ports mem_rd_en out 1, mem_rd_addr out MEM_AW and mem_rd_data in 128: single-port memory read, 1-cycle latency.
REQ-013 SHALL have ports mem_wr_en out 1, mem_wr_addr out MEM_AW and mem_wr_data out 128: memory write.
REQ-014 SHALL have ports busy out 1 (state != IDLE), rd_cmd_cnt out 16 (accepted read commands, wraps) and wr_beat_cnt out 16 (accepted write beats, wraps).

Function
REQ-015 SHALL implement FSM states IDLE, READ (issuing reads), DRAIN (all reads issued, buffer not empty).
REQ-016 SHALL drive rcc_ready = (state==IDLE) && !wcc_valid; rcc_ready SHALL NOT depend on rcc_valid, because the initiator raises valid only while ready is high.
REQ-017 SHALL drive wcc_ready = (state==IDLE); in IDLE a write beat takes priority over a simultaneous read command.
REQ-018 SHALL, on a wcc handshake, assert mem_wr_en in the same cycle with mem_wr_addr = wcc_dram_addr[MEM_AW+3:4], mem_wr_data = wcc_write_data, and increment wr_beat_cnt.
REQ-019 SHALL, on an rcc handshake with rcc_length>0, latch address, tag and length, increment rd_cmd_cnt and go to READ.
REQ-020 SHALL, on an rcc handshake with rcc_length==0, increment rd_cmd_cnt, stay in IDLE and emit no rcd beat.
REQ-021 SHALL, in READ, assert mem_rd_en only when buffered + in-flight beats, after this cycle's pop, stay <= 2; mem_rd_addr = base + beat index, wrapping modulo 2^MEM_AW.
REQ-022 SHALL move to DRAIN after the cycle issuing beat rcc_length-1, and from DRAIN to IDLE in the cycle after the last beat is popped.
REQ-023 SHALL capture mem_rd_data one cycle after each mem_rd_en into a 2-entry buffer in issue order; no beat is lost or duplicated under any rcd_ready pattern.
REQ-024 SHALL present rcd_valid from the buffer head; a beat pops on rcd_valid && rcd_ready, and rcd_read_data SHALL hold stable while valid && !ready.
REQ-025 SHALL hold rcd_dpram_addr and rcd_length at the latched command values for every beat of the burst.
REQ-026 SHALL meet this latency, with cycle 0 = accept cycle: first mem_rd_en in cycle 1, rcd_valid first high in cycle 3; with rcd_ready held high, one beat per cycle sustained.
REQ-027 SHALL keep mem_rd_en and mem_wr_en mutually exclusive in every cycle.

Reset
REQ-028 SHALL, while reset is high, clear state to IDLE, empty the buffer, discard in-flight reads and zero both counters.
REQ-029 SHALL, while reset is high, drive rcc_ready=0, wcc_ready=0, rcd_valid=0, mem_rd_en=0, mem_wr_en=0, busy=0 and all data/address outputs to 0.
REQ-030 SHALL treat reset during a burst as a full abort, with no rcd beat emitted after reset deasserts.

Structure
REQ-031 SHALL place the FSM state enum, the 128-bit word width constant and the MEM_AW default in shared package tsn_dgcl_pkg.
REQ-032 SHALL implement the 2-entry ordered buffer (push/pop/count, stable head) as sub-module tsn_dgcl_skid.

Verification
REQ-033 SHALL cover: preload words 0x10..0x13; rcc addr 0x100, tag 0x4005, len 4, rcd_ready=1 -> 4 consecutive beats of words 0x10..0x13 from cycle 3, tag 0x4005, len 4, busy drops in cycle 8.
REQ-034 SHALL cover: same command with rcd_ready toggling 1,0,0,1,... -> identical 4 beats in order, data stable while stalled, at most 2 outstanding.
REQ-035 SHALL cover: rcc and wcc valid in the same IDLE cycle -> write done first (wr_beat_cnt=1), read accepted the next cycle and returns the newly written data when the addresses match.
REQ-036 SHALL cover: rcc len 0 -> no rcd_valid, rd_cmd_cnt increments, rcc_ready high the next cycle.
REQ-037 SHALL cover: MEM_AW=4, start word 0xE, len 4 -> words 0xE, 0xF, 0x0, 0x1.
REQ-038 SHALL cover: reset asserted after beat 2 of 8 -> all outputs at reset values, no further rcd beats, and a subsequent command completes normally.

Source files
------------

// File: rtl/tsn_dgcl_pkg.sv
// Shared types and constants for the DGCL responder: FSM states, word width
// and the default local-memory address width.
package tsn_dgcl_pkg;

  localparam int WORD_W         = 128;
  localparam int MEM_AW_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/tsn_dgcl_skid.sv
// Two-entry in-order beat buffer. The head entry stays put until it is popped,
// so the consumer sees stable data while stalled.
module tsn_dgcl_skid
  import tsn_dgcl_pkg::*;
#(
  parameter int W = WORD_W
) (
  input  logic         gemmini_clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         valid,
  output logic [W-1:0] head_data,
  output logic [1:0]   count
);

  logic [W-1:0] entry [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count_q;
  logic         push_ok;
  logic         pop_ok;

  assign pop_ok    = pop && (count_q != 2'd0);
  assign push_ok   = push && ((count_q != 2'd2) || pop_ok);
  assign valid     = (count_q != 2'd0);
  assign head_data = entry[rd_ptr];
  assign count     = count_q;

  always_ff @(posedge gemmini_clk or posedge reset) begin
    if (reset) begin
      entry[0] <= '0;
      entry[1] <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_ok) begin
        entry[wr_ptr] <= push_data;
        wr_ptr        <= ~wr_ptr;
      end
      if (pop_ok) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/tsn_dgcl_resp.sv
// DGCL responder: serves burst read commands from local memory through a
// 2-deep buffer and performs single-beat writes, writes winning in IDLE.
module tsn_dgcl_resp
  import tsn_dgcl_pkg::*;
#(
  parameter int MEM_AW = MEM_AW_DEFAULT
) (
  input  logic                gemmini_clk,
  input  logic                reset,
  input  logic                rcc_valid,
  output logic                rcc_ready,
  input  logic [39:0]         rcc_dram_addr,
  input  logic [15:0]         rcc_dpram_addr,
  input  logic [15:0]         rcc_length,
  output logic                rcd_valid,
  input  logic                rcd_ready,
  output logic [WORD_W-1:0]   rcd_read_data,
  output logic [15:0]         rcd_dpram_addr,
  output logic [15:0]         rcd_length,
  input  logic                wcc_valid,
  output logic                wcc_ready,
  input  logic [39:0]         wcc_dram_addr,
  input  logic [WORD_W-1:0]   wcc_write_data,
  input  logic [15:0]         wcc_dpram_addr,
  input  logic [15:0]         wcc_length,
  output logic                mem_rd_en,
  output logic [MEM_AW-1:0]   mem_rd_addr,
  input  logic [WORD_W-1:0]   mem_rd_data,
  output logic                mem_wr_en,
  output logic [MEM_AW-1:0]   mem_wr_addr,
  output logic [WORD_W-1:0]   mem_wr_data,
  output logic                busy,
  output logic [15:0]         rd_cmd_cnt,
  output logic [15:0]         wr_beat_cnt
);

  state_t            state;
  logic [MEM_AW-1:0] rd_addr_q;
  logic [15:0]       issue_idx;
  logic [15:0]       len_q;
  logic [15:0]       tag_q;
  logic              inflight;
  logic [1:0]        buf_count;
  logic              buf_valid;
  logic              rcc_fire;
  logic              wcc_fire;
  logic              pop;
  logic              issue;
  logic [2:0]        occ_after;
  logic              unused_bits;

  assign unused_bits = ^{wcc_dpram_addr, wcc_length,
                         rcc_dram_addr[3:0], rcc_dram_addr[39:MEM_AW+4],
                         wcc_dram_addr[3:0], wcc_dram_addr[39:MEM_AW+4]};

  // Readies are gated by reset so nothing is accepted while it is held.
  assign wcc_ready = (state == IDLE) && !reset;
  assign rcc_ready = (state == IDLE) && !wcc_valid && !reset;
  assign wcc_fire  = wcc_valid && wcc_ready;
  assign rcc_fire  = rcc_valid && rcc_ready;

  assign rcd_valid      = buf_valid;
  assign pop            = buf_valid && rcd_ready;
  assign rcd_dpram_addr = tag_q;
  assign rcd_length     = len_q;
  assign busy           = (state != IDLE);

  // Buffered plus in-flight beats after this cycle's pop must leave room for one more.
  assign occ_after   = {1'b0, buf_count} + {2'b00, inflight} - {2'b00, pop};
  assign issue       = (state == READ) && (occ_after <= 3'd1);
  assign mem_rd_en   = issue;
  assign mem_rd_addr = issue ? rd_addr_q : '0;

  assign mem_wr_en   = wcc_fire;
  assign mem_wr_addr = wcc_fire ? wcc_dram_addr[MEM_AW+3:4] : '0;
  assign mem_wr_data = wcc_fire ? wcc_write_data : '0;

  tsn_dgcl_skid #(.W(WORD_W)) u_skid (
    .gemmini_clk (gemmini_clk),
    .reset       (reset),
    .push        (inflight),
    .push_data   (mem_rd_data),
    .pop         (pop),
    .valid       (buf_valid),
    .head_data   (rcd_read_data),
    .count       (buf_count)
  );

  always_ff @(posedge gemmini_clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      rd_addr_q   <= '0;
      issue_idx   <= 16'd0;
      len_q       <= 16'd0;
      tag_q       <= 16'd0;
      inflight    <= 1'b0;
      rd_cmd_cnt  <= 16'd0;
      wr_beat_cnt <= 16'd0;
    end else begin
      inflight <= issue;
      if (wcc_fire) wr_beat_cnt <= wr_beat_cnt + 16'd1;
      if (rcc_fire) rd_cmd_cnt  <= rd_cmd_cnt + 16'd1;
      case (state)
        IDLE: begin
          if (rcc_fire && (rcc_length != 16'd0)) begin
            rd_addr_q <= rcc_dram_addr[MEM_AW+3:4];
            tag_q     <= rcc_dpram_addr;
            len_q     <= rcc_length;
            issue_idx <= 16'd0;
            state     <= READ;
          end
        end
        READ: begin
          if (issue) begin
            rd_addr_q <= rd_addr_q + 1'b1;
            issue_idx <= issue_idx + 16'd1;
            if (issue_idx == len_q - 16'd1) state <= DRAIN;
          end
        end
        DRAIN: begin
          // Leave only once the last beat has been popped and nothing is in flight.
          if ((buf_count == 2'd0) && !inflight) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tsn_dgcl_resp.sv
// Directed bench for tsn_dgcl_resp: an IDLE handshake vector table plus
// hand-written burst, stall, priority, wrap and abort sequences.
module tb_tsn_dgcl_resp;

  logic         gemmini_clk;
  logic         reset;
  logic         rcc_valid;
  logic         rcc_ready;
  logic [39:0]  rcc_dram_addr;
  logic [15:0]  rcc_dpram_addr;
  logic [15:0]  rcc_length;
  logic         rcd_valid;
  logic         rcd_ready;
  logic [127:0] rcd_read_data;
  logic [15:0]  rcd_dpram_addr;
  logic [15:0]  rcd_length;
  logic         wcc_valid;
  logic         wcc_ready;
  logic [39:0]  wcc_dram_addr;
  logic [127:0] wcc_write_data;
  logic [15:0]  wcc_dpram_addr;
  logic [15:0]  wcc_length;
  logic         mem_rd_en;
  logic [15:0]  mem_rd_addr;
  logic [127:0] mem_rd_data;
  logic         mem_wr_en;
  logic [15:0]  mem_wr_addr;
  logic [127:0] mem_wr_data;
  logic         busy;
  logic [15:0]  rd_cmd_cnt;
  logic [15:0]  wr_beat_cnt;

  // Second instance with a 4-bit word address for the wrap case.
  logic         rcc4_valid;
  logic         rcc4_ready;
  logic [39:0]  rcc4_addr;
  logic [15:0]  rcc4_len;
  logic         rcd4_valid;
  logic         rcd4_ready;
  logic [127:0] rcd4_data;
  logic         mem4_rd_en;
  logic [3:0]   mem4_rd_addr;
  logic [127:0] mem4_rd_data;
  logic         tie_wcc_valid;
  logic [39:0]  tie_addr;
  logic [127:0] tie_data;
  logic [15:0]  tie_16;
  logic [15:0]  unused4_tag;
  logic [15:0]  unused4_len;
  logic         unused4_wcc_ready;
  logic         unused4_wr_en;
  logic [3:0]   unused4_wr_addr;
  logic [127:0] unused4_wr_data;
  logic         unused4_busy;
  logic [15:0]  unused4_rd_cnt;
  logic [15:0]  unused4_wr_cnt;

  int checks = 0;
  int errors = 0;

  bit           written [256];
  logic [127:0] wdata   [256];

  typedef struct packed {
    logic         rv;
    logic         wv;
    logic [15:0]  len;
    logic [39:0]  waddr;
    logic [127:0] wdata;
    logic         exp_rr;
    logic         exp_wr;
    logic         exp_wen;
    logic [15:0]  exp_waddr;
    logic [127:0] exp_wdata;
    logic [15:0]  exp_rd_cnt;
    logic [15:0]  exp_wr_cnt;
  } vec_t;

  vec_t tbl [6];

  tsn_dgcl_resp dut (
    .gemmini_clk(gemmini_clk), .reset(reset),
    .rcc_valid(rcc_valid), .rcc_ready(rcc_ready), .rcc_dram_addr(rcc_dram_addr),
    .rcc_dpram_addr(rcc_dpram_addr), .rcc_length(rcc_length),
    .rcd_valid(rcd_valid), .rcd_ready(rcd_ready), .rcd_read_data(rcd_read_data),
    .rcd_dpram_addr(rcd_dpram_addr), .rcd_length(rcd_length),
    .wcc_valid(wcc_valid), .wcc_ready(wcc_ready), .wcc_dram_addr(wcc_dram_addr),
    .wcc_write_data(wcc_write_data), .wcc_dpram_addr(wcc_dpram_addr), .wcc_length(wcc_length),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .busy(busy), .rd_cmd_cnt(rd_cmd_cnt), .wr_beat_cnt(wr_beat_cnt)
  );

  tsn_dgcl_resp #(.MEM_AW(4)) dut4 (
    .gemmini_clk(gemmini_clk), .reset(reset),
    .rcc_valid(rcc4_valid), .rcc_ready(rcc4_ready), .rcc_dram_addr(rcc4_addr),
    .rcc_dpram_addr(tie_16), .rcc_length(rcc4_len),
    .rcd_valid(rcd4_valid), .rcd_ready(rcd4_ready), .rcd_read_data(rcd4_data),
    .rcd_dpram_addr(unused4_tag), .rcd_length(unused4_len),
    .wcc_valid(tie_wcc_valid), .wcc_ready(unused4_wcc_ready), .wcc_dram_addr(tie_addr),
    .wcc_write_data(tie_data), .wcc_dpram_addr(tie_16), .wcc_length(tie_16),
    .mem_rd_en(mem4_rd_en), .mem_rd_addr(mem4_rd_addr), .mem_rd_data(mem4_rd_data),
    .mem_wr_en(unused4_wr_en), .mem_wr_addr(unused4_wr_addr), .mem_wr_data(unused4_wr_data),
    .busy(unused4_busy), .rd_cmd_cnt(unused4_rd_cnt), .wr_beat_cnt(unused4_wr_cnt)
  );

  function automatic logic [127:0] pat(input logic [15:0] a);
    return {16'hC0DE, a, 96'h0123_4567_89AB_CDEF_0011_2233};
  endfunction

  initial begin
    gemmini_clk = 1'b0;
    forever #5 gemmini_clk = ~gemmini_clk;
  end

  // Memory models: unwritten words return a fixed pattern of their address.
  always @(posedge gemmini_clk) begin
    if (mem_wr_en) begin
      written[mem_wr_addr[7:0]] <= 1'b1;
      wdata[mem_wr_addr[7:0]]   <= mem_wr_data;
    end
    if (mem_rd_en)
      mem_rd_data <= written[mem_rd_addr[7:0]] ? wdata[mem_rd_addr[7:0]] : pat(mem_rd_addr);
  end

  always @(posedge gemmini_clk) begin
    if (mem4_rd_en) mem4_rd_data <= pat({12'h000, mem4_rd_addr});
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge gemmini_clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issues one read command and follows it to completion, scoring every beat.
  task automatic run_burst(input logic [39:0] addr, input logic [15:0] tag, input logic [15:0] len,
                           input bit toggle, input bit ovr, input logic [127:0] ovr_data,
                           input logic [15:0] exp_rd_cnt);
    int beats = 0;
    int issued = 0;
    int last_pop = -1;
    int busy_drop = -1;
    bit ovf = 1'b0;
    logic pv = 1'b0;
    logic pr = 1'b0;
    logic [127:0] pd = '0;
    logic [127:0] exp;
    logic [15:0] w;
    w = addr[19:4];
    rcc_valid      = 1'b1;
    rcc_dram_addr  = addr;
    rcc_dpram_addr = tag;
    rcc_length     = len;
    for (int cyc = 0; cyc < 40 && busy_drop < 0; cyc++) begin
      rcd_ready = toggle ? (cyc % 3 == 0) : 1'b1;
      #1;
      if (cyc == 0) check_output("rcc_ready_at_accept", rcc_ready, 1);
      if (cyc == 1) begin
        check_output("first_rd_en_cycle1", mem_rd_en, 1);
        check_output("rd_cmd_cnt", rd_cmd_cnt, exp_rd_cnt);
        check_output("busy_in_burst", busy, 1);
      end
      if (cyc > 0 && !busy && busy_drop < 0) busy_drop = cyc;
      if (cyc < 3) check_output("no_early_rcd_valid", rcd_valid, 0);
      if (cyc == 3) check_output("rcd_valid_cycle3", rcd_valid, 1);
      if (mem_rd_en) begin
        check_output("mem_rd_addr", mem_rd_addr, w + 16'(issued));
        issued++;
      end
      if (pv && !pr) begin
        check_output("stall_valid_held", rcd_valid, 1);
        check_output("stall_data_stable", rcd_read_data, pd);
      end
      if (rcd_valid && rcd_ready) begin
        exp = (ovr && beats == 0) ? ovr_data : pat(w + 16'(beats));
        check_output("rcd_read_data", rcd_read_data, exp);
        check_output("rcd_dpram_addr", rcd_dpram_addr, tag);
        check_output("rcd_length", rcd_length, len);
        beats++;
        last_pop = cyc;
      end
      if (issued - beats > 2) ovf = 1'b1;
      pv = rcd_valid;
      pr = rcd_ready;
      pd = rcd_read_data;
      tick();
      rcc_valid = 1'b0;
    end
    check_output("beat_count", 128'(beats), 128'(len));
    check_output("issue_count", 128'(issued), 128'(len));
    check_output("outstanding_le_2", ovf, 0);
    if (!toggle) begin
      check_output("last_pop_cycle", 128'(last_pop), 128'(3 + len - 1));
      check_output("busy_drop_cycle", 128'(busy_drop), 128'(3 + len + 1));
    end else begin
      check_output("burst_completed", busy_drop > 0, 1);
    end
  endtask

  initial begin
    logic [3:0] ew [4];
    int beats4;
    int iss4;
    int pops;
    bit stray;
    logic [127:0] d35;
    ew[0] = 4'hE; ew[1] = 4'hF; ew[2] = 4'h0; ew[3] = 4'h1;

    reset = 1'b1;
    rcc_valid = 1'b0; rcc_dram_addr = '0; rcc_dpram_addr = '0; rcc_length = '0;
    rcd_ready = 1'b0;
    wcc_valid = 1'b0; wcc_dram_addr = '0; wcc_write_data = '0;
    wcc_dpram_addr = 16'hFFFF; wcc_length = 16'hFFFF;
    rcc4_valid = 1'b0; rcc4_addr = '0; rcc4_len = '0; rcd4_ready = 1'b1;
    tie_wcc_valid = 1'b0; tie_addr = '0; tie_data = '0; tie_16 = '0;

    tbl[0] = '{rv:1'b0, wv:1'b0, len:16'd0, waddr:40'h0,   wdata:128'h0,
               exp_rr:1'b1, exp_wr:1'b1, exp_wen:1'b0, exp_waddr:16'h0,  exp_wdata:128'h0,
               exp_rd_cnt:16'd0, exp_wr_cnt:16'd0};
    tbl[1] = '{rv:1'b1, wv:1'b0, len:16'd0, waddr:40'h0,   wdata:128'h0,
               exp_rr:1'b1, exp_wr:1'b1, exp_wen:1'b0, exp_waddr:16'h0,  exp_wdata:128'h0,
               exp_rd_cnt:16'd1, exp_wr_cnt:16'd0};
    tbl[2] = '{rv:1'b1, wv:1'b0, len:16'd0, waddr:40'h0,   wdata:128'h0,
               exp_rr:1'b1, exp_wr:1'b1, exp_wen:1'b0, exp_waddr:16'h0,  exp_wdata:128'h0,
               exp_rd_cnt:16'd2, exp_wr_cnt:16'd0};
    tbl[3] = '{rv:1'b0, wv:1'b1, len:16'd0, waddr:40'h200, wdata:128'hAAAA_0001,
               exp_rr:1'b0, exp_wr:1'b1, exp_wen:1'b1, exp_waddr:16'h20, exp_wdata:128'hAAAA_0001,
               exp_rd_cnt:16'd2, exp_wr_cnt:16'd1};
    tbl[4] = '{rv:1'b1, wv:1'b1, len:16'd0, waddr:40'h215, wdata:128'hBBBB_0002,
               exp_rr:1'b0, exp_wr:1'b1, exp_wen:1'b1, exp_waddr:16'h21, exp_wdata:128'hBBBB_0002,
               exp_rd_cnt:16'd2, exp_wr_cnt:16'd2};
    tbl[5] = '{rv:1'b1, wv:1'b0, len:16'd0, waddr:40'h0,   wdata:128'h0,
               exp_rr:1'b1, exp_wr:1'b1, exp_wen:1'b0, exp_waddr:16'h0,  exp_wdata:128'h0,
               exp_rd_cnt:16'd3, exp_wr_cnt:16'd2};

    // Reset values, with a write offered during reset that must be ignored.
    tick();
    tick();
    wcc_valid = 1'b1; wcc_dram_addr = 40'h400; wcc_write_data = 128'h1234;
    #1;
    check_output("reset_rcc_ready", rcc_ready, 0);
    check_output("reset_wcc_ready", wcc_ready, 0);
    check_output("reset_mem_wr_en", mem_wr_en, 0);
    check_output("reset_mem_wr_data", mem_wr_data, 0);
    check_output("reset_busy", busy, 0);
    check_output("reset_rd_cmd_cnt", rd_cmd_cnt, 0);
    check_output("reset_wr_beat_cnt", wr_beat_cnt, 0);
    check_output("reset_rcd_valid", rcd_valid, 0);
    tick();
    reset = 1'b0;
    wcc_valid = 1'b0;

    // Address wrap on the 4-bit instance.
    rcc4_valid = 1'b1; rcc4_addr = 40'hE0; rcc4_len = 16'd4;
    beats4 = 0;
    iss4 = 0;
    for (int cyc = 0; cyc < 20 && beats4 < 4; cyc++) begin
      #1;
      if (cyc == 0) check_output("aw4_rcc_ready", rcc4_ready, 1);
      if (mem4_rd_en) begin
        if (iss4 < 4) check_output("aw4_rd_addr", mem4_rd_addr, ew[iss4]);
        iss4++;
      end
      if (rcd4_valid) begin
        check_output("aw4_rcd_data", rcd4_data, pat({12'h000, ew[beats4]}));
        beats4++;
      end
      tick();
      rcc4_valid = 1'b0;
    end
    check_output("aw4_beats", 128'(beats4), 128'd4);

    // IDLE handshake table: priority, zero-length commands and writes.
    for (int i = 0; i < 6; i++) begin
      rcc_valid = tbl[i].rv;
      rcc_length = tbl[i].len;
      rcc_dram_addr = 40'h100;
      wcc_valid = tbl[i].wv;
      wcc_dram_addr = tbl[i].waddr;
      wcc_write_data = tbl[i].wdata;
      #1;
      check_output($sformatf("vec%0d_rcc_ready", i), rcc_ready, tbl[i].exp_rr);
      check_output($sformatf("vec%0d_wcc_ready", i), wcc_ready, tbl[i].exp_wr);
      check_output($sformatf("vec%0d_mem_wr_en", i), mem_wr_en, tbl[i].exp_wen);
      check_output($sformatf("vec%0d_mem_wr_addr", i), mem_wr_addr, tbl[i].exp_waddr);
      check_output($sformatf("vec%0d_mem_wr_data", i), mem_wr_data, tbl[i].exp_wdata);
      check_output($sformatf("vec%0d_mem_rd_en", i), mem_rd_en, 0);
      tick();
      check_output($sformatf("vec%0d_rd_cmd_cnt", i), rd_cmd_cnt, tbl[i].exp_rd_cnt);
      check_output($sformatf("vec%0d_wr_beat_cnt", i), wr_beat_cnt, tbl[i].exp_wr_cnt);
      check_output($sformatf("vec%0d_busy", i), busy, 0);
      check_output($sformatf("vec%0d_rcd_valid", i), rcd_valid, 0);
    end
    rcc_valid = 1'b0;
    wcc_valid = 1'b0;

    run_burst(40'h100, 16'h4005, 16'd4, 1'b0, 1'b0, '0, 16'd4);
    run_burst(40'h100, 16'h4005, 16'd4, 1'b1, 1'b0, '0, 16'd5);

    // Simultaneous read and write to the same word: write first, read sees it.
    d35 = 128'hFEED_FACE_0000_0035;
    rcc_valid = 1'b1; rcc_dram_addr = 40'h300; rcc_dpram_addr = 16'h1111; rcc_length = 16'd1;
    wcc_valid = 1'b1; wcc_dram_addr = 40'h300; wcc_write_data = d35;
    #1;
    check_output("prio_rcc_ready", rcc_ready, 0);
    check_output("prio_mem_wr_en", mem_wr_en, 1);
    check_output("prio_mem_wr_addr", mem_wr_addr, 16'h30);
    tick();
    wcc_valid = 1'b0;
    check_output("prio_wr_beat_cnt", wr_beat_cnt, 16'd3);
    run_burst(40'h300, 16'h1111, 16'd1, 1'b0, 1'b1, d35, 16'd6);

    // Abort an 8-beat burst after its second beat.
    rcc_valid = 1'b1; rcc_dram_addr = 40'h100; rcc_dpram_addr = 16'h0007; rcc_length = 16'd8;
    rcd_ready = 1'b1;
    pops = 0;
    for (int cyc = 0; cyc < 20 && pops < 2; cyc++) begin
      #1;
      if (rcd_valid && rcd_ready) pops++;
      tick();
      rcc_valid = 1'b0;
    end
    check_output("abort_two_beats_seen", 128'(pops), 128'd2);
    reset = 1'b1;
    rcc_valid = 1'b1;
    wcc_valid = 1'b1; wcc_dram_addr = 40'h500; wcc_write_data = 128'h5555;
    #1;
    check_output("abort_rcc_ready", rcc_ready, 0);
    check_output("abort_wcc_ready", wcc_ready, 0);
    check_output("abort_rcd_valid", rcd_valid, 0);
    check_output("abort_mem_rd_en", mem_rd_en, 0);
    check_output("abort_mem_wr_en", mem_wr_en, 0);
    check_output("abort_busy", busy, 0);
    check_output("abort_rcd_read_data", rcd_read_data, 0);
    check_output("abort_rcd_dpram_addr", rcd_dpram_addr, 0);
    check_output("abort_rcd_length", rcd_length, 0);
    check_output("abort_mem_rd_addr", mem_rd_addr, 0);
    check_output("abort_mem_wr_addr", mem_wr_addr, 0);
    check_output("abort_mem_wr_data", mem_wr_data, 0);
    check_output("abort_rd_cmd_cnt", rd_cmd_cnt, 0);
    check_output("abort_wr_beat_cnt", wr_beat_cnt, 0);
    tick();
    tick();
    reset = 1'b0;
    rcc_valid = 1'b0;
    wcc_valid = 1'b0;
    stray = 1'b0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      #1;
      if (rcd_valid || mem_rd_en || busy) stray = 1'b1;
      tick();
    end
    check_output("abort_no_stray_beats", stray, 0);
    run_burst(40'h100, 16'h4005, 16'd4, 1'b0, 1'b0, '0, 16'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
